mem_access_stage: RTL and testbench

Memory-access (MEM) stage controller that consumes the execute stage's results and drives a variable-latency data-memory port. It takes the ALU result as the effective address and rs2 data as store data, and uses funct3 to select the width. It generates a word-aligned request with byte enables and waits for the memory acknowledge while stalling upstream. It then returns sign- or zero-extended load data to writeback, and reports misaligned or illegal accesses and bus timeouts.

---
 rtl/mem_access_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage controller: turns EX results into one word-aligned data-memory
// request, waits for ack or timeout, and returns extended load data.
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_fault,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] ld_q, ld_d;
    logic        lvld_q, lvld_d;
    logic        fault_q, fault_d;
    logic        berr_q, berr_d;

    logic        illegal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        illegal = (mem_read & mem_write)
                | (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)
                | (mem_write & funct3[2])
                | ((funct3[1:0] == 2'b01) & alu_result[0])
                | ((funct3[1:0] == 2'b10) & (|alu_result[1:0]));
    end

    // Store data is replicated across lanes so the memory only needs the byte enables.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << alu_result[1:0];
                wdata_new = {4{write_data[7:0]}};
            end
            2'b01: begin
                be_new    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{write_data[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = write_data;
            end
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = dmem_rdata[7:0];
            2'd1:    rd_byte = dmem_rdata[15:8];
            2'd2:    rd_byte = dmem_rdata[23:16];
            default: rd_byte = dmem_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        ld_d    = ld_q;
        lvld_d  = 1'b0;
        fault_d = 1'b0;
        berr_d  = 1'b0;
        if (state_q == IDLE) begin
            if (ex_valid && (mem_read || mem_write)) begin
                if (illegal) begin
                    fault_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {alu_result[31:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    f3_d    = funct3;
                    lane_d  = alu_result[1:0];
                end
            end
        end else begin
            // Ack takes precedence over a timeout in the same cycle.
            if (dmem_ack) begin
                state_d = IDLE;
                req_d   = 1'b0;
                if (!we_q) begin
                    ld_d   = rd_ext;
                    lvld_d = 1'b1;
                end
            end else if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                req_d   = 1'b0;
                berr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            ld_q    <= 32'd0;
            lvld_q  <= 1'b0;
            fault_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            ld_q    <= ld_d;
            lvld_q  <= lvld_d;
            fault_q <= fault_d;
            berr_q  <= berr_d;
        end
    end

    assign stall      = (state_q == WAIT);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign load_data  = ld_q;
    assign load_valid = lvld_q;
    assign mem_fault  = fault_q;
    assign bus_error  = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_access_stage;

    localparam int TO = 4;
    localparam int K_REQ = 0, K_LOAD = 1, K_FAULT = 2, K_BERR = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        bit          chkw;
        logic [31:0] data;
    } ev_t;

    logic        clk, rst;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, write_data;
    logic        stall, load_valid, mem_fault, bus_error;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    ev_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    logic req_prev = 1'b0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .alu_result(alu_result), .write_data(write_data),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .mem_fault(mem_fault), .bus_error(bus_error),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [3:0] be,
                        input logic we, input bit chkw, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.addr = a; e.be = be; e.we = we; e.chkw = chkw; e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == K_REQ) begin
            chk("req_addr", dmem_addr, e.addr);
            chk("req_be", {28'd0, dmem_be}, {28'd0, e.be});
            chk("req_we", {31'd0, dmem_we}, {31'd0, e.we});
            if (e.chkw) chk("req_wdata", dmem_wdata, e.data);
        end else if (kind == K_LOAD) begin
            chk("load_data", load_data, e.data);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (dmem_req && !req_prev) pop_check(K_REQ);
        if (load_valid) pop_check(K_LOAD);
        if (mem_fault) pop_check(K_FAULT);
        if (bus_error) pop_check(K_BERR);
        req_prev = dmem_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        ex_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; alu_result = a; write_data = d;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // k = 0: expect fault; k > 0: ack in k-th WAIT cycle; k < 0: never ack.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rword, input int k);
        drive(rd, wr, f3, a, d);
        step();
        idle_in();
        if (k == 0) begin
            @(negedge clk);
            chk("fault_noreq", {31'd0, dmem_req}, 32'd0);
            chk("fault_nostall", {31'd0, stall}, 32'd0);
        end else begin
            int n;
            n = (k < 0) ? TO : k;
            for (int i = 1; i <= n; i++) begin
                @(negedge clk);
                chk("req_held", {31'd0, dmem_req}, 32'd1);
                chk("stall_wait", {31'd0, stall}, 32'd1);
                if (i == n && k > 0) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rword;
                end
                step();
            end
            dmem_ack = 1'b0;
            @(negedge clk);
            chk("req_drop", {31'd0, dmem_req}, 32'd0);
            chk("stall_drop", {31'd0, stall}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; alu_result = 32'd0; write_data = 32'd0;
        step(); step();
        @(negedge clk);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_be_we", {27'd0, dmem_be, dmem_we}, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_pulses", {29'd0, load_valid, mem_fault, bus_error}, 32'd0);
        rst = 1'b0;
        step();

        // Directed vectors
        push(K_REQ, 32'h100, 4'b1111, 1'b1, 1'b1, 32'hDEADBEEF);
        run(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
        chk("sw_no_load", {31'd0, load_valid}, 32'd0);

        push(K_REQ, 32'h100, 4'b1000, 1'b0, 1'b0, 32'h0);
        push(K_LOAD, 32'h0, 4'h0, 1'b0, 1'b0, 32'hFFFFFF80);
        run(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 3);

        push(K_REQ, 32'h100, 4'b1000, 1'b0, 1'b0, 32'h0);
        push(K_LOAD, 32'h0, 4'h0, 1'b0, 1'b0, 32'h00000080);
        run(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 3);

        push(K_REQ, 32'h100, 4'b1100, 1'b0, 1'b0, 32'h0);
        push(K_LOAD, 32'h0, 4'h0, 1'b0, 1'b0, 32'h000080FF);
        run(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 3);

        push(K_REQ, 32'h100, 4'b1100, 1'b1, 1'b1, 32'hABCDABCD);
        run(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1);
        chk("load_hold", load_data, 32'h000080FF);

        push(K_FAULT, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        run(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
        push(K_FAULT, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        run(0, 1, 3'b100, 32'h104, 32'h0, 32'h0, 0);

        push(K_REQ, 32'h100, 4'b0011, 1'b0, 1'b0, 32'h0);
        push(K_LOAD, 32'h0, 4'h0, 1'b0, 1'b0, 32'hFFFF8001);
        run(1, 0, 3'b001, 32'h100, 32'h0, 32'h12348001, 2);

        push(K_REQ, 32'h100, 4'b0010, 1'b0, 1'b0, 32'h0);
        push(K_LOAD, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0000007F);
        run(1, 0, 3'b000, 32'h101, 32'h0, 32'h12347F01, 1);

        push(K_REQ, 32'h104, 4'b0100, 1'b1, 1'b1, 32'hA5A5A5A5);
        run(0, 1, 3'b000, 32'h106, 32'h000000A5, 32'h0, 1);

        push(K_FAULT, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        run(0, 1, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        push(K_FAULT, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        run(1, 0, 3'b011, 32'h108, 32'h0, 32'h0, 0);
        push(K_FAULT, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        run(1, 1, 3'b010, 32'h010, 32'h0, 32'h0, 0);

        // Timeout: no ack, then ack exactly on the last allowed cycle
        push(K_REQ, 32'h108, 4'b1111, 1'b0, 1'b0, 32'h0);
        push(K_BERR, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        run(1, 0, 3'b010, 32'h108, 32'h0, 32'h0, -1);

        push(K_REQ, 32'h10C, 4'b1111, 1'b0, 1'b0, 32'h0);
        push(K_LOAD, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0BADF00D);
        run(1, 0, 3'b010, 32'h10C, 32'h0, 32'h0BADF00D, TO);

        // Reset in the second WAIT cycle, late ack afterwards
        push(K_REQ, 32'h300, 4'b1111, 1'b0, 1'b0, 32'h0);
        drive(1, 0, 3'b010, 32'h300, 32'h0);
        step();
        idle_in();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rstw_req", {31'd0, dmem_req}, 32'd0);
        chk("rstw_stall", {31'd0, stall}, 32'd0);
        chk("rstw_bus", dmem_addr | dmem_wdata | {27'd0, dmem_be, dmem_we}, 32'd0);
        chk("rstw_load", load_data, 32'd0);
        step();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("rstw_ack_ignored", {30'd0, load_valid, dmem_req}, 32'd0);

        // Back-to-back LW then SW with ex_valid held through the stall
        push(K_REQ, 32'h200, 4'b1111, 1'b0, 1'b0, 32'h0);
        push(K_LOAD, 32'h0, 4'h0, 1'b0, 1'b0, 32'hCAFEF00D);
        push(K_REQ, 32'h204, 4'b1111, 1'b1, 1'b1, 32'h13579BDF);
        drive(1, 0, 3'b010, 32'h200, 32'h0);
        step();
        @(negedge clk);
        chk("b2b_req1", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_ack = 1'b0;
        drive(0, 1, 3'b010, 32'h204, 32'h13579BDF);
        @(negedge clk);
        chk("b2b_gap", {30'd0, dmem_req, load_valid}, 32'd1);
        step();
        idle_in();
        @(negedge clk);
        chk("b2b_req2", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("b2b_req2_drop", {31'd0, dmem_req}, 32'd0);
        chk("b2b_load_kept", load_data, 32'hCAFEF00D);

        repeat (4) step();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
